// File: rtl/core_fetch_unit_pkg.sv
// rtl/core_fetch_unit_pkg.sv - shared defines and package constants for the fetch stage
`ifndef CORE_DEFINES_SVH
`define CORE_DEFINES_SVH
`define CPURstAddress  32'h0000_0000
`define JumpEnable     1'b1
`define JumpDisable    1'b0
`define HoldEnable     1'b1
`define HoldNone       1'b0
`define InstAddressBus 31:0
`define InstByteBus    7:0
`define INST_NOP       32'h0000_0013
`endif

package core_fetch_unit_pkg;

  localparam logic [31:0]  CPU_RST_ADDRESS = `CPURstAddress;
  localparam logic [31:0]  INST_NOP_WORD   = `INST_NOP;
  localparam int unsigned  DEFAULT_DEPTH   = 4;
  localparam int unsigned  FETCH_STEP      = 4;

endpackage

// File: rtl/core_fetch_unit_if.sv
// rtl/core_fetch_unit_if.sv - ROM request path and IF/ID handshake bundle
interface core_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);

  logic              rom_req_out;
  logic [ADDR_W-1:0] rom_addr_out;
  logic [INST_W-1:0] rom_data_in;
  logic              inst_valid_out;
  logic              inst_ready_in;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_addr_out;

  // Fetch unit side: issues ROM reads and presents the head instruction.
  modport master (
    output rom_req_out, rom_addr_out, inst_valid_out, inst_out, inst_addr_out,
    input  rom_data_in, inst_ready_in
  );

  // Environment side: the ROM and the IF/ID consumer.
  modport slave (
    input  rom_req_out, rom_addr_out, inst_valid_out, inst_out, inst_addr_out,
    output rom_data_in, inst_ready_in
  );

endinterface

// File: rtl/core_sync_fifo.sv
// rtl/core_sync_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
module core_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop on an empty FIFO is ignored; a push when full is dropped and flagged below.
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == FULL_CNT);

  // Pointers wrap naturally; count disambiguates full from empty; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage array carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // The producer reserves space before requesting, so a push at full is a design bug.
  always_ff @(posedge clk) begin
    if (rst_n && i_push && !i_flush)
      assert (r_count != FULL_CNT) else $error("core_sync_fifo: push while full");
  end

endmodule

// File: rtl/core_fetch_unit.sv
// rtl/core_fetch_unit.sv - PC generator, 1-cycle ROM request path and prefetch FIFO
module core_fetch_unit
  import core_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(CPU_RST_ADDRESS),
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(INST_NOP_WORD)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag_in,
  input  logic [ADDR_W-1:0]          jump_addr_in,
  input  logic                       hold_flag_in,
  core_fetch_unit_if.master          bus,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_out
);

  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = ADDR_W + INST_W;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_inflight_addr;
  logic               r_inflight;

  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W:0]     w_occupancy;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_push_data;
  logic               w_unused_jump_lsb;

  // The target is always word aligned; the low address bits carry no meaning.
  assign w_unused_jump_lsb = ^{jump_addr_in[1:0], w_full};

  // Space check counts the request still in flight so its response always fits.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue     = rst & !jump_flag_in & !hold_flag_in & (w_occupancy < DEPTH_LIM);

  // A jump discards the response of the previous request and any pop this cycle.
  assign w_push      = r_inflight & !jump_flag_in;
  assign w_pop       = !w_empty & bus.inst_ready_in & !jump_flag_in;
  assign w_push_data = {r_inflight_addr, bus.rom_data_in};

  // PC advances on each issue, redirects on jump, and freezes otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc            <= RST_ADDR;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (jump_flag_in) begin
        r_pc <= {jump_addr_in[ADDR_W-1:2], 2'b00};
      end else if (w_issue) begin
        r_pc            <= r_pc + ADDR_W'(FETCH_STEP);
        r_inflight_addr <= r_pc;
      end
    end
  end

  core_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_prefetch_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_flush     (jump_flag_in),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign bus.rom_req_out    = w_issue;
  assign bus.rom_addr_out   = r_pc;
  assign bus.inst_valid_out = !w_empty;
  assign bus.inst_out       = w_empty ? NOP_INST : w_head[INST_W-1:0];
  assign bus.inst_addr_out  = w_empty ? '0 : w_head[ENTRY_W-1:INST_W];
  assign pc_out             = r_pc;
  assign fifo_count_out     = w_count;

endmodule

// File: tb/tb_core_fetch_unit.sv
// tb/tb_core_fetch_unit.sv - directed self-checking bench for core_fetch_unit
module tb_core_fetch_unit;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        hold_flag;
  logic [31:0] pc_out;
  logic [2:0]  fifo_count;
  int          n_total;
  int          n_pass;

  core_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

  core_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (4),
    .RST_ADDR (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_flag_in   (jump_flag),
    .jump_addr_in   (jump_addr),
    .hold_flag_in   (hold_flag),
    .bus            (bus),
    .pc_out         (pc_out),
    .fifo_count_out (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // ROM model: registered read, data valid one cycle after the address.
  always @(posedge clk) bus.rom_data_in <= rom_word(bus.rom_addr_out);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic reset_dut(input logic rdy);
    @(negedge clk);
    rst = 1'b0; jump_flag = 1'b0; hold_flag = 1'b0; jump_addr = '0;
    bus.inst_ready_in = 1'b0;
    #1;
    chk("rst_valid", bus.inst_valid_out, 1'b0);
    chk("rst_inst",  bus.inst_out, 32'h13);
    chk("rst_iaddr", bus.inst_addr_out, 32'h0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_req",   bus.rom_req_out, 1'b0);
    chk("rst_pc",    pc_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.inst_ready_in = rdy;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; jump_flag = 1'b0; jump_addr = '0; hold_flag = 1'b0;
    bus.inst_ready_in = 1'b0;
    n_total = 0; n_pass = 0;

    // Streaming after reset release with ready high.
    reset_dut(1'b1);
    #1 chk("t1_req0", bus.rom_req_out, 1'b1); chk("t1_addr0", bus.rom_addr_out, 32'h0);
    chk("t1_valid0", bus.inst_valid_out, 1'b0);
    @(negedge clk); #1 chk("t1_addr1", bus.rom_addr_out, 32'h4); chk("t1_valid1", bus.inst_valid_out, 1'b0);
    @(negedge clk); #1 chk("t1_addr2", bus.rom_addr_out, 32'h8); chk("t1_valid2", bus.inst_valid_out, 1'b1);
    chk("t1_head0", bus.inst_addr_out, 32'h0); chk("t1_inst0", bus.inst_out, rom_word(32'h0));
    @(negedge clk); #1 chk("t1_head1", bus.inst_addr_out, 32'h4);
    @(negedge clk); #1 chk("t1_head2", bus.inst_addr_out, 32'h8); chk("t1_count", fifo_count, 3'd1);

    // Backpressure fills the FIFO, then drains in order.
    reset_dut(1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1 chk("t2_req_w3", bus.rom_req_out, 1'b1);
    @(negedge clk); #1 chk("t2_req_w4", bus.rom_req_out, 1'b0); chk("t2_count_w4", fifo_count, 3'd3);
    @(negedge clk); #1 chk("t2_count_w5", fifo_count, 3'd4);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1 chk("t2_count_full", fifo_count, 3'd4); chk("t2_req_full", bus.rom_req_out, 1'b0);
    chk("t2_head_hold", bus.inst_addr_out, 32'h0); chk("t2_inst_hold", bus.inst_out, rom_word(32'h0));
    @(negedge clk); bus.inst_ready_in = 1'b1;
    #1 chk("t2_drain0", bus.inst_addr_out, 32'h0);
    @(negedge clk); #1 chk("t2_drain1", bus.inst_addr_out, 32'h4); chk("t2_req_resume", bus.rom_addr_out, 32'h10);
    @(negedge clk); #1 chk("t2_drain2", bus.inst_addr_out, 32'h8);
    @(negedge clk); #1 chk("t2_drain3", bus.inst_addr_out, 32'hC);

    // Jump with 3 entries queued plus one in flight.
    reset_dut(1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(negedge clk); jump_flag = 1'b1; jump_addr = 32'h103;
    #1 chk("t3_count_pre", fifo_count, 3'd3); chk("t3_req_jump", bus.rom_req_out, 1'b0);
    @(negedge clk); jump_flag = 1'b0;
    #1 chk("t3_count_flush", fifo_count, 3'd0); chk("t3_valid_flush", bus.inst_valid_out, 1'b0);
    chk("t3_inst_nop", bus.inst_out, 32'h13); chk("t3_req_tgt", bus.rom_req_out, 1'b1);
    chk("t3_addr_tgt", bus.rom_addr_out, 32'h100);
    @(negedge clk); #1 chk("t3_no_stale", fifo_count, 3'd0);
    @(negedge clk); #1 chk("t3_valid_tgt", bus.inst_valid_out, 1'b1);
    chk("t3_head_tgt", bus.inst_addr_out, 32'h100); chk("t3_inst_tgt", bus.inst_out, rom_word(32'h100));

    // Hold for five cycles while the consumer drains.
    reset_dut(1'b1);
    @(negedge clk);
    @(negedge clk); hold_flag = 1'b1;
    #1 chk("t4_req_hold", bus.rom_req_out, 1'b0); chk("t4_pc_hold0", pc_out, 32'h8);
    chk("t4_head0", bus.inst_addr_out, 32'h0);
    @(negedge clk); #1 chk("t4_landed", bus.inst_addr_out, 32'h4); chk("t4_count_land", fifo_count, 3'd1);
    @(negedge clk); #1 chk("t4_empty", bus.inst_valid_out, 1'b0); chk("t4_pc_hold1", pc_out, 32'h8);
    @(negedge clk); @(negedge clk);
    #1 chk("t4_req_hold_end", bus.rom_req_out, 1'b0); chk("t4_pc_hold2", pc_out, 32'h8);
    @(negedge clk); hold_flag = 1'b0;
    #1 chk("t4_req_resume", bus.rom_req_out, 1'b1); chk("t4_addr_resume", bus.rom_addr_out, 32'h8);
    @(negedge clk); #1 chk("t4_valid_gap", bus.inst_valid_out, 1'b0);
    @(negedge clk); #1 chk("t4_head_resume", bus.inst_addr_out, 32'h8);

    // PC wraps past the top of the address space.
    reset_dut(1'b1);
    jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFF;
    #1 chk("t5_req_jump", bus.rom_req_out, 1'b0);
    @(negedge clk); jump_flag = 1'b0;
    #1 chk("t5_addr_top", bus.rom_addr_out, 32'hFFFF_FFFC);
    @(negedge clk); #1 chk("t5_addr_wrap", bus.rom_addr_out, 32'h0);
    @(negedge clk); #1 chk("t5_head_top", bus.inst_addr_out, 32'hFFFF_FFFC);
    @(negedge clk); #1 chk("t5_head_wrap", bus.inst_addr_out, 32'h0);

    // Asynchronous reset pulsed mid-stream.
    reset_dut(1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1 chk("t6_count_pre", fifo_count, 3'd1); chk("t6_pc_pre", pc_out, 32'h10);
    rst = 1'b0;
    #1 chk("t6_valid_rst", bus.inst_valid_out, 1'b0); chk("t6_inst_rst", bus.inst_out, 32'h13);
    chk("t6_iaddr_rst", bus.inst_addr_out, 32'h0); chk("t6_count_rst", fifo_count, 3'd0);
    chk("t6_req_rst", bus.rom_req_out, 1'b0); chk("t6_pc_rst", pc_out, 32'h0);
    @(negedge clk); rst = 1'b1;
    #1 chk("t6_req_post", bus.rom_req_out, 1'b1); chk("t6_addr_post", bus.rom_addr_out, 32'h0);
    @(negedge clk); #1 chk("t6_dropped", bus.inst_valid_out, 1'b0);
    @(negedge clk); #1 chk("t6_head_post", bus.inst_addr_out, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
